// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration chain loader: FSM state encodings
// and the words-per-load helper.
package config_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int calc_nw(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/config_word_buffer.sv
// One-entry holding register between the host handshake and the shifter.
// out_data/out_valid expose either the held word or, when empty, the word arriving this cycle.
module config_word_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_fire,
  input  logic         take,
  output logic         full,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (in_fire && !take) begin
      full   <= 1'b1;
      data_q <= in_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

  assign out_valid = full || in_fire;
  assign out_data  = full ? data_q : in_data;

endmodule

// File: rtl/config_chain_loader.sv
// Serialises host configuration words LSB-first onto a tile_config chain and
// issues a single commit strobe once the whole chain has been shifted.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | waiting for the first word of a load
// SHIFT  | one chain bit per clock from the shifter
// COMMIT | set_soft or set_hard strobe
// DONE   | done pulse, back to IDLE
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hard_sel,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              shift_bit,
  output logic              set_soft,
  output logic              set_hard,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int NW  = calc_nw(CHAIN_LEN, WORD_W);
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam int RCW = $clog2(WORD_W + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0] NW_C     = WCW'(NW);
  localparam logic [RCW-1:0] WORD_W_C = RCW'(WORD_W);
  localparam logic [RCW-1:0] ONE_LEFT = RCW'(1);

  logic [2:0]        state;
  logic              hard_q;
  logic              underrun_q;
  logic [WORD_W-1:0] shifter;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [RCW-1:0]    wbits_left;

  logic              accept;
  logic              take;
  logic              last_bit;
  logic              word_end;
  logic              buf_full;
  logic              buf_valid;
  logic [WORD_W-1:0] buf_data;

  assign busy       = (state != ST_IDLE);
  assign word_ready = busy && !buf_full && (word_cnt < NW_C) && !abort;
  assign accept     = word_ready && word_valid;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign word_end   = (wbits_left == ONE_LEFT);

  // The shifter refills either from LOAD or when its final bit leaves mid-chain.
  assign take = ((state == ST_LOAD) && accept) ||
                ((state == ST_SHIFT) && word_end && !last_bit && buf_valid);

  config_word_buffer #(.W(WORD_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .in_data  (word_in),
    .in_fire  (accept),
    .take     (take),
    .full     (buf_full),
    .out_valid(buf_valid),
    .out_data (buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hard_q     <= 1'b0;
      underrun_q <= 1'b0;
      shifter    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      wbits_left <= '0;
    end else begin
      if (accept) word_cnt <= word_cnt + 1'b1;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_LOAD;
              hard_q     <= hard_sel;
              underrun_q <= 1'b0;
              bit_cnt    <= '0;
              word_cnt   <= '0;
            end
          end
          ST_LOAD: begin
            if (take) begin
              shifter    <= buf_data;
              wbits_left <= WORD_W_C;
              state      <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              state <= ST_COMMIT;
            end else if (word_end) begin
              // The chain has no enable, so a missing word here is unrecoverable.
              if (buf_valid) begin
                shifter    <= buf_data;
                wbits_left <= WORD_W_C;
              end else begin
                state      <= ST_IDLE;
                underrun_q <= 1'b1;
              end
            end else begin
              shifter    <= shifter >> 1;
              wbits_left <= wbits_left - 1'b1;
            end
          end
          ST_COMMIT: state <= ST_DONE;
          ST_DONE:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  assign shift_bit = (state == ST_SHIFT) && shifter[0];
  assign set_soft  = (state == ST_COMMIT) && !hard_q;
  assign set_hard  = (state == ST_COMMIT) && hard_q;
  assign done      = (state == ST_DONE);
  assign underrun  = underrun_q;

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Sequencer that loads a serial configuration bitstream into a chain of `tile_config` tiles. It accepts configuration words from a host over a valid/ready handshake and serialises them LSB-first onto the chain's `shift_in_soft` input at one bit per clock. After the last bit it issues a single-cycle commit strobe on `set_soft` or `set_hard`. It sits between the fabric configuration port and the first tile of the chain, and its busy/done/underrun status is visible to the host.

## Interface
- `CHAIN_LEN`, 14: total configuration bits in the chain (≥1).
- `WORD_W`, 8: host word width (≥1).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a load (sampled in IDLE only).
- `hard_sel` input 1: captured at start; 1 = commit via `set_hard`, 0 = commit via `set_soft`.
- `abort` input 1: synchronous cancel; has priority over all other inputs except `rst`.
- `word_in` input WORD_W: host configuration word; bit 0 is shifted first.
- `word_valid` input 1: `word_in` valid.
- `word_ready` output 1: loader accepts `word_in` this cycle.
- `shift_bit` output 1: drives the chain's `shift_in_soft`.
- `set_soft` output 1: commit strobe (soft).
- `set_hard` output 1: commit strobe (hard).
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after a successful commit.
- `underrun` output 1: sticky error flag, cleared by the next accepted `start`.

## Operation
- Words per load: NW = ceil(CHAIN_LEN/WORD_W). The last word carries CHAIN_LEN − (NW−1)·WORD_W valid bits; its upper bits are discarded.
- States:
  - IDLE: `shift_bit`=0; `start` → LOAD and captures `hard_sel`.
  - LOAD: waits for the first word; `shift_bit`=0. An accepted word is placed in the shifter → SHIFT.
  - SHIFT: `shift_bit` = shifter[0] every cycle; the bit counter increments.
  - COMMIT: one cycle; the selected set strobe = 1, `shift_bit`=0 → DONE.
  - DONE: one cycle; `done`=1 → IDLE.
- A one-entry prefetch buffer sits behind the shifter.
  - `word_ready` = busy && buffer empty && words_fetched < NW && !abort.
  - A word may also bypass straight into the shifter on the same edge the shifter's last bit is consumed.
- The chain shifts every clock and has no enable. A gap therefore corrupts the load:
  - Underrun is declared if the shifter finishes a word, bits remain, and neither the buffer nor a same-edge handshake supplies the next word.
  - On underrun: → IDLE, `underrun`=1, no set strobe.
- `abort` in any non-IDLE state → IDLE next edge; no strobe, no `done`; buffer flushed; `underrun` unchanged.
- `start` while busy is ignored.
- Counters:
  - bit counter is $clog2(CHAIN_LEN+1) bits wide.
  - word counter is $clog2(NW+1) bits wide.
  - Both reset to 0 on entry to LOAD.

## Timing
- Reset values: state IDLE; all outputs 0; buffer empty; counters 0; `underrun` 0.
- Reset asserted mid-load forces IDLE immediately (asynchronously); no strobe is emitted.
- `start` high at edge E → LOAD in cycle E+1, with `word_ready`=1.
- First word accepted at edge F → bit 0 on `shift_bit` in cycle F+1.
  - Bit k appears in cycle F+1+k.
  - The chain samples it at the end of that cycle.
- The last bit is in cycle F+CHAIN_LEN.
- COMMIT is in cycle F+CHAIN_LEN+1; `done` is in cycle F+CHAIN_LEN+2.
- Zero-latency host (valid always high) → the load never underruns.
- The next word must be accepted no later than the edge ending the current word's last bit.

## Structure
- Shared package `config_loader_pkg` holds:
  - state encodings (IDLE/LOAD/SHIFT/COMMIT/DONE);
  - a function computing NW.
- Sub-module `config_word_buffer`: one-entry valid/ready holding register with a same-cycle bypass output. The top level contains the FSM, shifter and counters.

## Test plan
- Default parameters (CHAIN_LEN=14, WORD_W=8); words 0xD5, 0x2A with valid always high:
  - `shift_bit` sequence is 1,0,1,0,1,0,1,1,0,1,0,1,0,1.
  - `set_soft` is high in exactly cycle F+15; `done` in F+16.
  - A behavioural `tile_config` model ends with the expected contents.
- Same load with `hard_sel`=1 → `set_hard` pulses and `set_soft` stays 0.
- Second word withheld until 3 cycles after the first word's last bit → `underrun`=1, no strobe, state IDLE. A following `start` clears `underrun`.
- Second word offered exactly on the edge of the first word's bit 7 (bypass) → no gap, no underrun, correct sequence.
- `abort` asserted at shift bit 5 → IDLE next cycle, no strobe, no `done`; `word_ready` goes 0.
- `rst` pulsed mid-SHIFT → all outputs 0 immediately. `start` while busy is ignored (bit count unchanged). CHAIN_LEN=8, WORD_W=8 → exactly one word requested.
